// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, drives a synchronous instruction memory
// and hands fetched words to decode through a 2-entry valid/ready buffer.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 16,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [ADDR_WIDTH-1:0]  imem_address,
  output logic                   imem_enable,
  input  logic [INSTR_WIDTH-1:0] imem_instruction,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   running,
  output logic                   fault
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [1:0]             state, state_next;
  logic [ADDR_WIDTH-1:0]  pc, pc_next;
  logic                   inflight;
  logic [ADDR_WIDTH-1:0]  inflight_pc;
  logic [1:0]             count;
  logic                   head;
  logic                   tail;
  logic [INSTR_WIDTH-1:0] fifo_data [2];
  logic [ADDR_WIDTH-1:0]  fifo_pc   [2];

  logic       pop, push, flush;
  logic [1:0] occ;
  logic       slot_free, fetch_try, pc_ok, issue, fault_go;

  always_comb begin
    pop       = instr_valid & instr_ready;
    flush     = redirect_valid && (state != FAULT);
    push      = inflight && !flush;
    occ       = count + {1'b0, inflight};
    // A slot is free if buffer+in-flight leave room, counting the word leaving this cycle
    slot_free = (occ <= 2'd1) || ((occ == 2'd2) && pop);
    fetch_try = (state == RUN) && !redirect_valid && !halt && slot_free;
    pc_ok     = {1'b0, pc} < DEPTH;
    issue     = fetch_try && pc_ok;
    fault_go  = fetch_try && !pc_ok;
    tail      = head ^ count[0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN: begin
        if (halt && redirect_valid) state_next = IDLE;
        else if (halt)              state_next = DRAIN;
        else if (fault_go)          state_next = FAULT;
      end
      DRAIN: begin
        if (redirect_valid)                  state_next = IDLE;
        else if ((count == 2'd0) && !inflight) state_next = IDLE;
      end
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_next = pc;
    if (flush)      pc_next = redirect_pc;
    else if (issue) pc_next = pc + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      inflight <= issue;
      if (issue) inflight_pc <= pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      head         <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
    end else begin
      if (pop) head <= ~head;
      if (push) begin
        fifo_data[tail] <= imem_instruction;
        fifo_pc[tail]   <= inflight_pc;
      end
      if (flush) begin
        count <= '0;
      end else begin
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  assign imem_address = pc;
  assign imem_enable  = issue;
  assign instr_valid  = (count != 2'd0);
  assign instr_data   = fifo_data[head];
  assign instr_pc     = fifo_pc[head];
  assign running      = (state == RUN);
  assign fault        = (state == FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: scoreboard of expected {pc,data} words
// popped by a monitor on each decode handshake, plus cycle-exact control checks.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt, redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_address;
  logic        imem_enable;
  logic [15:0] imem_instruction = '0;
  logic        instr_valid, instr_ready;
  logic [15:0] instr_data, instr_pc;
  logic        running, fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [15:0] mem [256];

  instruction_fetch_unit #(
    .ADDR_WIDTH (16),
    .INSTR_WIDTH(16),
    .MEM_DEPTH  (256),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_address    (imem_address),
    .imem_enable     (imem_enable),
    .imem_instruction(imem_instruction),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .running         (running),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

  always @(posedge clk)
    if (imem_enable) imem_instruction <= mem[imem_address[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] pc, input logic [15:0] data);
    exp_q.push_back({pc, data});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual_pc=%0h actual_data=%0h expected=none", instr_pc, instr_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("word_pc", {16'h0, instr_pc}, {16'h0, e[31:16]});
        check("word_data", {16'h0, instr_data}, {16'h0, e[15:0]});
      end
    end
  end

  always @(negedge clk)
    if (!reset && dut.count > 2'd2) begin
      errors++;
      $display("FAIL buffer_overflow actual=%0d required_max=2", dut.count);
    end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check_reset_values();
    check("rst_addr",    {16'h0, imem_address}, 32'h0);
    check("rst_enable",  {31'h0, imem_enable},  32'h0);
    check("rst_valid",   {31'h0, instr_valid},  32'h0);
    check("rst_data",    {16'h0, instr_data},   32'h0);
    check("rst_pc",      {16'h0, instr_pc},     32'h0);
    check("rst_running", {31'h0, running},      32'h0);
    check("rst_fault",   {31'h0, fault},        32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    tick(); reset = 1'b0;
    tick();

    // Start and stream pcs 0..6 with a 5-cycle stall at pc 3
    for (int i = 0; i < 7; i++) push_exp(16'(i), 16'h1000 + 16'(i));
    start = 1'b1;                                            // cycle c
    tick(); start = 1'b0;                                    // c+1
    @(negedge clk);
    check("start_running", {31'h0, running}, 32'h1);
    check("start_enable", {31'h0, imem_enable}, 32'h1);
    check("start_addr", {16'h0, imem_address}, 32'h0);
    check("start_valid_c1", {31'h0, instr_valid}, 32'h0);
    tick(); @(negedge clk);                                  // c+2
    check("start_valid_c2", {31'h0, instr_valid}, 32'h0);
    tick(); @(negedge clk);                                  // c+3
    check("start_valid_c3", {31'h0, instr_valid}, 32'h1);
    check("start_pc_c3", {16'h0, instr_pc}, 32'h0);
    tick(); tick(); tick();                                  // c+6
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, instr_valid}, 32'h1);
      check("stall_pc", {16'h0, instr_pc}, 32'h3);
      check("stall_data", {16'h0, instr_data}, 32'h1003);
      check("stall_enable", {31'h0, imem_enable}, 32'h0);
      check("stall_addr", {16'h0, imem_address}, 32'h5);
      tick();
    end
    instr_ready = 1'b1;                                      // c+11
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("resume_valid", {31'h0, instr_valid}, 32'h1);
      check("resume_pc", {16'h0, instr_pc}, 32'h3 + 32'(i));
      tick();
    end
    instr_ready = 1'b0;                                      // c+15
    tick();                                                  // c+16 = r

    // Redirect to 0x40 with two words buffered
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    push_exp(16'h0040, 16'h1040);
    push_exp(16'h0041, 16'h1041);
    push_exp(16'h0042, 16'h1042);
    @(negedge clk);
    check("pre_redirect_pc", {16'h0, instr_pc}, 32'h7);
    tick(); redirect_valid = 1'b0; instr_ready = 1'b1;       // r+1
    @(negedge clk);
    check("redir_valid_r1", {31'h0, instr_valid}, 32'h0);
    check("redir_enable_r1", {31'h0, imem_enable}, 32'h1);
    check("redir_addr_r1", {16'h0, imem_address}, 32'h40);
    tick(); @(negedge clk);                                  // r+2
    check("redir_valid_r2", {31'h0, instr_valid}, 32'h0);
    tick(); @(negedge clk);                                  // r+3
    check("redir_valid_r3", {31'h0, instr_valid}, 32'h1);
    check("redir_pc_r3", {16'h0, instr_pc}, 32'h40);

    // Halt with one word buffered and one in flight
    tick(); halt = 1'b1;                                     // r+4
    @(negedge clk);
    check("halt_enable", {31'h0, imem_enable}, 32'h0);
    check("halt_pc", {16'h0, instr_pc}, 32'h41);
    tick(); halt = 1'b0;                                     // r+5
    @(negedge clk);
    check("drain_running", {31'h0, running}, 32'h0);
    check("drain_enable", {31'h0, imem_enable}, 32'h0);
    check("drain_pc", {16'h0, instr_pc}, 32'h42);
    tick(); @(negedge clk);                                  // r+6
    check("drain_empty", {31'h0, instr_valid}, 32'h0);
    tick(); instr_ready = 1'b0;                              // r+7
    push_exp(16'h0043, 16'h1043);
    @(negedge clk);
    check("idle_running", {31'h0, running}, 32'h0);
    check("idle_addr", {16'h0, imem_address}, 32'h43);
    tick(); start = 1'b1;                                    // r+8
    tick(); start = 1'b0;                                    // r+9
    @(negedge clk);
    check("restart_enable", {31'h0, imem_enable}, 32'h1);
    check("restart_addr", {16'h0, imem_address}, 32'h43);
    tick(); tick();                                          // r+11
    @(negedge clk);
    check("restart_valid", {31'h0, instr_valid}, 32'h1);
    check("restart_data", {16'h0, instr_data}, 32'h1043);

    // Redirect to 0xFE with a handshake in the same cycle, then run off the end
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h00FE; instr_ready = 1'b1;  // r+12
    push_exp(16'h00FE, 16'h10FE);
    push_exp(16'h00FF, 16'h10FF);
    tick(); redirect_valid = 1'b0;                           // r+13
    @(negedge clk);
    check("fe_valid", {31'h0, instr_valid}, 32'h0);
    check("fe_addr", {16'h0, imem_address}, 32'hFE);
    check("fe_enable", {31'h0, imem_enable}, 32'h1);
    tick(); @(negedge clk);                                  // r+14
    check("ff_addr", {16'h0, imem_address}, 32'hFF);
    check("ff_enable", {31'h0, imem_enable}, 32'h1);
    tick(); @(negedge clk);                                  // r+15
    check("oob_enable", {31'h0, imem_enable}, 32'h0);
    check("oob_fault_pre", {31'h0, fault}, 32'h0);
    check("oob_addr", {16'h0, imem_address}, 32'h100);
    tick(); @(negedge clk);                                  // r+16
    check("fault_set", {31'h0, fault}, 32'h1);
    check("fault_running", {31'h0, running}, 32'h0);
    check("fault_drain_pc", {16'h0, instr_pc}, 32'hFF);
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h0010; start = 1'b1;  // r+17
    @(negedge clk);
    check("fault_empty", {31'h0, instr_valid}, 32'h0);
    tick(); redirect_valid = 1'b0; start = 1'b0;             // r+18
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("fault_sticky", {31'h0, fault}, 32'h1);
      check("fault_no_issue", {31'h0, imem_enable}, 32'h0);
      check("fault_addr_held", {16'h0, imem_address}, 32'h100);
      tick();
    end

    // Reset clears fault; then reset mid-flight
    reset = 1'b1;
    #1;
    check_reset_values();
    tick(); reset = 1'b0; instr_ready = 1'b0;
    start = 1'b1;                                            // c'
    tick(); start = 1'b0;
    tick(); tick();                                          // c'+3
    @(negedge clk);
    check("mid_valid", {31'h0, instr_valid}, 32'h1);
    check("mid_pc", {16'h0, instr_pc}, 32'h0);
    #2 reset = 1'b1;
    #1;
    check_reset_values();
    tick(); reset = 1'b0; instr_ready = 1'b1;
    push_exp(16'h0000, 16'h1000);
    start = 1'b1;                                            // c''
    tick(); start = 1'b0;
    @(negedge clk);
    check("rerun_addr", {16'h0, imem_address}, 32'h0);
    check("rerun_enable", {31'h0, imem_enable}, 32'h1);
    tick(); tick();                                          // c''+3
    @(negedge clk);
    check("rerun_valid", {31'h0, instr_valid}, 32'h1);
    tick(); instr_ready = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
